// File: rtl/mips_shift_pkg.sv
// Shared definitions for the multi-cycle MIPS shift unit: widths, op encodings
// and FSM states.
package mips_shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_RSVD = 2'b10,
        OP_SRA  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_unit_step.sv
// Combinational single step of the iterative shifter: shifts acc by `step`
// bits according to the latched op; the reserved op passes acc through.
module shift_step
    import mips_shift_pkg::*;
(
    input  logic [DATA_W-1:0]  acc,
    input  shift_op_e          op,
    input  logic [SHAMT_W-1:0] step,
    output logic [DATA_W-1:0]  acc_nxt
);

    always_comb begin
        acc_nxt = acc;
        case (op)
            OP_SLL:  acc_nxt = acc << step;
            OP_SRL:  acc_nxt = acc >> step;
            OP_SRA:  acc_nxt = $unsigned($signed(acc) >>> step);
            default: acc_nxt = acc;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit with start/done handshake.
// Define SHIFT_STEP4_EN to shift by 4 per cycle while at least 4 bits remain.
module shift_unit
    import mips_shift_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand,
    input  logic [31:0]       shamt_ext,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_e             state, state_nxt;
    logic [DATA_W-1:0]  acc, acc_step;
    shift_op_e          op_q;
    logic [SHAMT_W-1:0] cnt, step_amt, shamt;
    logic               accept, last_step;
    logic               unused_shamt;

    assign shamt        = shamt_ext[SHAMT_W-1:0];
    assign unused_shamt = ^shamt_ext[31:SHAMT_W];
    assign accept       = (state == IDLE) && start;

`ifdef SHIFT_STEP4_EN
    assign step_amt = (cnt >= SHAMT_W'(4)) ? SHAMT_W'(4) : SHAMT_W'(1);
`else
    assign step_amt = SHAMT_W'(1);
`endif

    assign last_step = (cnt == step_amt);

    shift_step u_step (
        .acc     (acc),
        .op      (op_q),
        .step    (step_amt),
        .acc_nxt (acc_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // result is loaded on the edge entering DONE so it is valid while done is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            op_q   <= OP_SLL;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            acc  <= operand;
            op_q <= shift_op_e'(op);
            cnt  <= shamt;
            if (shamt == '0) result <= operand;
        end else if (state == SHIFT) begin
            acc <= acc_step;
            cnt <= cnt - step_amt;
            if (last_step) result <= acc_step;
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_shift_unit;
    import mips_shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [31:0] shamt_ext;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          errs   = 0;
    int          checks = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    shift_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .operand   (operand),
        .shamt_ext (shamt_ext),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input int n);
        case (o)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b11:   return $unsigned($signed(a) >>> n);
            default: return a;
        endcase
    endfunction

    function automatic int latency(input int n);
`ifdef SHIFT_STEP4_EN
        return 1 + n / 4 + n % 4;
`else
        return 1 + n;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s,
                          input bit inject);
        int          n, lat, c, c_done;
        logic [31:0] exp;
        bit          seen;
        n   = int'(s[4:0]);
        lat = latency(n);
        exp = model(o, a, n);
        check("idle_before", {31'b0, busy}, 32'd0);
        op = o; operand = a; shamt_ext = s; start = 1'b1;
        @(posedge clk);
        #1;
        // scramble inputs after accept; DUT must not re-sample
        start = 1'b0; op = ~o; operand = ~a; shamt_ext = $urandom;
        seen = 0; c_done = 0;
        for (c = 1; c <= lat + 1 && !seen; c++) begin
            @(negedge clk);
            if (inject && c == 2 && lat >= 2) begin
                start = 1'b1; operand = $urandom; op = 2'($urandom); shamt_ext = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen   = 1;
                c_done = c;
                check("result", result, exp);
                check("busy_at_done", {31'b0, busy}, 32'd1);
            end else begin
                check("busy_during", {31'b0, busy}, 32'd1);
                check("result_held", result, last_res);
            end
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        check("latency", 32'(c_done), 32'(lat));
        start = 1'b0;
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd0);
        check("busy_after", {31'b0, busy}, 32'd0);
        check("result_after", result, exp);
        last_res = exp;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; operand = '0; shamt_ext = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        reset_n = 1'b1;

        run_op(2'b00, 32'h0000_0001, 32'd31, 0);
        run_op(2'b11, 32'h8000_0000, 32'd4, 0);
        run_op(2'b01, 32'h8000_0000, 32'd4, 0);
        run_op(2'b01, 32'hDEAD_BEEF, 32'd0, 0);
        run_op(2'b00, 32'h0000_000F, 32'hFFFF_FFE3, 0);
        run_op(2'b01, 32'hF0F0_F0F0, 32'd10, 1);
        run_op(2'b10, 32'h1234_5678, 32'd7, 0);
        run_op(2'b11, 32'h7FFF_FFFF, 32'd31, 0);
        for (int i = 0; i < 40; i++)
            run_op(2'($urandom), $urandom, $urandom, bit'($urandom_range(0, 1)));

        // asynchronous abort mid-shift
        check("idle_before_abort", {31'b0, busy}, 32'd0);
        op = 2'b00; operand = 32'h0000_0003; shamt_ext = 32'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        last_res = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'b00, 32'h0000_0001, 32'd1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
